rob_commit: RTL

Retirement stage directly downstream of the reorder buffer. Watches the ROB head entry and retires completed instructions in program order, one per cycle. Register results go to the register file. Stores go to the data-memory port through a request/acknowledge handshake. A mispredicted branch flushes the ROB and redirects fetch.

---
 rtl/rob_pkg.sv | 21 ++
 rtl/rob_commit_perf_ctr.sv | 23 ++
 rtl/rob_commit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and default widths for the reorder buffer and its commit stage.
package rob_pkg;

  localparam int ROB_DATA_W = 16;
  localparam int ROB_TAG_W  = 3;
  localparam int ROB_REG_W  = 3;

  typedef enum logic [1:0] {
    OP_REG    = 2'b00,
    OP_STORE  = 2'b01,
    OP_BRANCH = 2'b10,
    OP_NOP    = 2'b11
  } rob_op_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    ST_WAIT = 2'b01,
    FLUSH   = 2'b10
  } commit_state_t;

endpackage

// File: rtl/rob_commit_perf_ctr.sv
// Retirement and mispredict-flush event counters for the commit stage.
// Only instantiated when COMMIT_PERF_EN is defined.
module commit_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire,
  input  logic        flush,
  output logic [31:0] retired_cnt,
  output logic [15:0] flush_cnt
);

  // Free-running wrapping counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      flush_cnt   <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + 32'd1;
      if (flush)  flush_cnt   <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/rob_commit.sv
// In-order retirement stage watching the ROB head: register writes, store
// handshake with data memory, and mispredict flush/redirect.
// Optional feature: define COMMIT_PERF_EN to build the retire/flush counters;
// otherwise retired_cnt and flush_cnt are tied to zero.
module rob_commit
  import rob_pkg::*;
#(
  parameter int DATA_W = ROB_DATA_W,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int REG_W  = ROB_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rob_empty,
  input  logic              rob_ready,
  input  rob_op_t           rob_op,
  input  logic [TAG_W-1:0]  rob_tag,
  input  logic [REG_W-1:0]  rob_dest,
  input  logic [DATA_W-1:0] rob_value,
  input  logic [DATA_W-1:0] rob_addr,
  input  logic              rob_mispredict,
  output logic              rob_re,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_idx,
  output logic [DATA_W-1:0] rf_data,
  output logic [TAG_W-1:0]  rf_tag,
  output logic              st_req,
  output logic [DATA_W-1:0] st_addr,
  output logic [DATA_W-1:0] st_data,
  input  logic              st_ack,
  output logic              flush,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [31:0]       retired_cnt,
  output logic [15:0]       flush_cnt
);

  commit_state_t state, state_n;
  logic          committable;
  logic          take_store;
  logic          take_mispredict;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  // Next state and commit strobes; everything held low while in reset.
  always_comb begin
    state_n         = state;
    rob_re          = 1'b0;
    rf_we           = 1'b0;
    take_store      = 1'b0;
    take_mispredict = 1'b0;
    committable     = !rob_empty && rob_ready;
    if (!rst) begin
      case (state)
        RUN: begin
          if (committable) begin
            case (rob_op)
              OP_REG: begin
                rob_re = 1'b1;
                rf_we  = 1'b1;
              end
              OP_STORE: begin
                // The store stays at the head until memory acknowledges it.
                take_store = 1'b1;
                state_n    = ST_WAIT;
              end
              OP_BRANCH: begin
                rob_re = 1'b1;
                if (rob_mispredict) begin
                  take_mispredict = 1'b1;
                  state_n         = FLUSH;
                end
              end
              default: rob_re = 1'b1;
            endcase
          end
        end
        ST_WAIT: begin
          if (st_ack) begin
            rob_re  = 1'b1;
            state_n = RUN;
          end
        end
        FLUSH:   state_n = RUN;
        default: state_n = RUN;
      endcase
    end
  end

  // Store request and redirect target captured when the head is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_addr     <= '0;
      st_data     <= '0;
      redirect_pc <= '0;
    end else begin
      if (take_store) begin
        st_addr <= rob_addr;
        st_data <= rob_value;
      end
      if (take_mispredict) redirect_pc <= rob_addr;
    end
  end

  assign st_req  = (state == ST_WAIT) && !rst;
  assign flush   = (state == FLUSH) && !rst;
  assign rf_idx  = rf_we ? rob_dest  : '0;
  assign rf_data = rf_we ? rob_value : '0;
  assign rf_tag  = rf_we ? rob_tag   : '0;

`ifdef COMMIT_PERF_EN
  commit_perf_ctr u_perf (
    .clk         (clk),
    .rst         (rst),
    .retire      (rob_re),
    .flush       (flush),
    .retired_cnt (retired_cnt),
    .flush_cnt   (flush_cnt)
  );
`else
  assign retired_cnt = '0;
  assign flush_cnt   = '0;
`endif

endmodule
